rob_retire: RTL and testbench

Eight-entry reorder buffer with in-order retirement for the Tomasulo core. The issue stage allocates an entry per decoded instruction and receives a 3-bit ROB tag. Execution units post results by tag over the common data bus. The block retires completed entries strictly in program order, at most one per cycle, and drives register-file writeback and rename release from the ROB head.

---
 rtl/rob_retire.sv | 140 ++++++++++++++
 tb/tb_rob_retire.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_retire.sv
// Eight-entry reorder buffer: allocate at tail, CDB writeback by tag,
// in-order retirement from head at most one entry per cycle.
module rob_retire (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alloc_valid,
  output logic       alloc_ready,
  input  logic [3:0] alloc_opcode,
  input  logic [3:0] alloc_dest,
  output logic [2:0] alloc_tag,
  input  logic       wb_valid,
  input  logic [2:0] wb_tag,
  input  logic [7:0] wb_value,
  output logic       ret_valid,
  output logic       ret_wen,
  output logic [3:0] ret_dest,
  output logic [7:0] ret_value,
  output logic [2:0] ret_tag,
  output logic [3:0] count,
  output logic       empty,
  output logic       full
);

  localparam logic [3:0] OP_STORE = 4'b0100;

  logic [7:0]      busy_q, busy_d;
  logic [7:0]      done_q, done_d;
  logic [7:0][3:0] op_q, op_d;
  logic [7:0][3:0] dest_q, dest_d;
  logic [7:0][7:0] val_q, val_d;
  logic [2:0]      head_q, head_d;
  logic [2:0]      tail_q, tail_d;
  logic [3:0]      count_q, count_d;
  logic            ret_valid_q, ret_valid_d;
  logic            ret_wen_q, ret_wen_d;
  logic [3:0]      ret_dest_q, ret_dest_d;
  logic [7:0]      ret_value_q, ret_value_d;
  logic [2:0]      ret_tag_q, ret_tag_d;

  logic do_alloc;
  logic do_wb;
  logic do_ret;

  assign full        = (count_q == 4'd8);
  assign empty       = (count_q == 4'd0);
  assign count       = count_q;
  assign alloc_ready = !full;
  assign alloc_tag   = tail_q;

  assign ret_valid = ret_valid_q;
  assign ret_wen   = ret_wen_q;
  assign ret_dest  = ret_dest_q;
  assign ret_value = ret_value_q;
  assign ret_tag   = ret_tag_q;

  // No bypass: a full buffer refuses allocation even while retiring.
  assign do_alloc = alloc_valid && !full;
  assign do_wb    = wb_valid && busy_q[wb_tag] && !done_q[wb_tag];
  assign do_ret   = busy_q[head_q] && done_q[head_q];

  always_comb begin
    busy_d      = busy_q;
    done_d      = done_q;
    op_d        = op_q;
    dest_d      = dest_q;
    val_d       = val_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    ret_valid_d = do_ret;
    ret_wen_d   = ret_wen_q;
    ret_dest_d  = ret_dest_q;
    ret_value_d = ret_value_q;
    ret_tag_d   = ret_tag_q;

    if (do_ret) begin
      ret_wen_d        = (op_q[head_q] != OP_STORE);
      ret_dest_d       = dest_q[head_q];
      ret_value_d      = val_q[head_q];
      ret_tag_d        = head_q;
      busy_d[head_q]   = 1'b0;
      done_d[head_q]   = 1'b0;
      head_d           = head_q + 3'd1;
    end else begin
      ret_wen_d = 1'b0;
    end

    if (do_wb) begin
      val_d[wb_tag]  = wb_value;
      done_d[wb_tag] = 1'b1;
    end

    if (do_alloc) begin
      busy_d[tail_q] = 1'b1;
      done_d[tail_q] = 1'b0;
      op_d[tail_q]   = alloc_opcode;
      dest_d[tail_q] = alloc_dest;
      tail_d         = tail_q + 3'd1;
    end

    unique case ({do_alloc, do_ret})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      done_q      <= '0;
      op_q        <= '0;
      dest_q      <= '0;
      val_q       <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      ret_valid_q <= 1'b0;
      ret_wen_q   <= 1'b0;
      ret_dest_q  <= '0;
      ret_value_q <= '0;
      ret_tag_q   <= '0;
    end else begin
      busy_q      <= busy_d;
      done_q      <= done_d;
      op_q        <= op_d;
      dest_q      <= dest_d;
      val_q       <= val_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      ret_valid_q <= ret_valid_d;
      ret_wen_q   <= ret_wen_d;
      ret_dest_q  <= ret_dest_d;
      ret_value_q <= ret_value_d;
      ret_tag_q   <= ret_tag_d;
    end
  end

endmodule

// File: tb/tb_rob_retire.sv
// Directed bench for rob_retire: vector table plus
// hand-written full, wrap and mid-operation reset sequences.
module tb_rob_retire;

  logic       clk;
  logic       rst_n;
  logic       alloc_valid;
  logic       alloc_ready;
  logic [3:0] alloc_opcode;
  logic [3:0] alloc_dest;
  logic [2:0] alloc_tag;
  logic       wb_valid;
  logic [2:0] wb_tag;
  logic [7:0] wb_value;
  logic       ret_valid;
  logic       ret_wen;
  logic [3:0] ret_dest;
  logic [7:0] ret_value;
  logic [2:0] ret_tag;
  logic [3:0] count;
  logic       empty;
  logic       full;

  int checks;
  int errors;

  rob_retire dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_valid  (alloc_valid),
    .alloc_ready  (alloc_ready),
    .alloc_opcode (alloc_opcode),
    .alloc_dest   (alloc_dest),
    .alloc_tag    (alloc_tag),
    .wb_valid     (wb_valid),
    .wb_tag       (wb_tag),
    .wb_value     (wb_value),
    .ret_valid    (ret_valid),
    .ret_wen      (ret_wen),
    .ret_dest     (ret_dest),
    .ret_value    (ret_value),
    .ret_tag      (ret_tag),
    .count        (count),
    .empty        (empty),
    .full         (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       av;
    logic [3:0] op;
    logic [3:0] dst;
    logic       wv;
    logic [2:0] wt;
    logic [7:0] wval;
    logic [2:0] e_atag;
    logic       e_rv;
    logic       e_wen;
    logic [3:0] e_dst;
    logic [7:0] e_val;
    logic [2:0] e_rtag;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    alloc_valid  = 1'b0;
    alloc_opcode = 4'd0;
    alloc_dest   = 4'd0;
    wb_valid     = 1'b0;
    wb_tag       = 3'd0;
    wb_value     = 8'd0;
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 1'b0;
    tick();
    chk("rst count", int'(count), 0);
    chk("rst empty", int'(empty), 1);
    chk("rst full", int'(full), 0);
    chk("rst ready", int'(alloc_ready), 1);
    chk("rst ret_valid", int'(ret_valid), 0);
    chk("rst alloc_tag", int'(alloc_tag), 0);
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(
    input logic av, input logic [3:0] op, input logic [3:0] dst,
    input logic wv, input logic [2:0] wt, input logic [7:0] wval,
    input logic [2:0] e_atag, input logic e_rv, input logic e_wen,
    input logic [3:0] e_dst, input logic [7:0] e_val,
    input logic [2:0] e_rtag, input logic [3:0] e_cnt);
    vec_t v;
    v.av = av; v.op = op; v.dst = dst;
    v.wv = wv; v.wt = wt; v.wval = wval;
    v.e_atag = e_atag; v.e_rv = e_rv; v.e_wen = e_wen;
    v.e_dst = e_dst; v.e_val = e_val;
    v.e_rtag = e_rtag; v.e_cnt = e_cnt;
    return v;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle_in();

    // in-order retire, then store with duplicate writeback
    tbl[0]  = mk(1, 4'h1, 4'd1, 0, 3'd0, 8'h00, 3'd0, 0, 0, 0, 0, 0, 4'd1);
    tbl[1]  = mk(1, 4'h0, 4'd2, 0, 3'd0, 8'h00, 3'd1, 0, 0, 0, 0, 0, 4'd2);
    tbl[2]  = mk(1, 4'h2, 4'd3, 0, 3'd0, 8'h00, 3'd2, 0, 0, 0, 0, 0, 4'd3);
    tbl[3]  = mk(0, 4'h0, 4'd0, 1, 3'd2, 8'h30, 3'd3, 0, 0, 0, 0, 0, 4'd3);
    tbl[4]  = mk(0, 4'h0, 4'd0, 1, 3'd0, 8'h10, 3'd3, 0, 0, 0, 0, 0, 4'd3);
    tbl[5]  = mk(0, 4'h0, 4'd0, 1, 3'd1, 8'h20, 3'd3,
                 1, 1, 4'd1, 8'h10, 3'd0, 4'd2);
    tbl[6]  = mk(0, 4'h0, 4'd0, 0, 3'd0, 8'h00, 3'd3,
                 1, 1, 4'd2, 8'h20, 3'd1, 4'd1);
    tbl[7]  = mk(0, 4'h0, 4'd0, 0, 3'd0, 8'h00, 3'd3,
                 1, 1, 4'd3, 8'h30, 3'd2, 4'd0);
    tbl[8]  = mk(0, 4'h0, 4'd0, 0, 3'd0, 8'h00, 3'd3, 0, 0, 0, 0, 0, 4'd0);
    tbl[9]  = mk(1, 4'h4, 4'd5, 0, 3'd0, 8'h00, 3'd3, 0, 0, 0, 0, 0, 4'd1);
    tbl[10] = mk(0, 4'h0, 4'd0, 1, 3'd3, 8'h55, 3'd4, 0, 0, 0, 0, 0, 4'd1);
    tbl[11] = mk(0, 4'h0, 4'd0, 1, 3'd3, 8'h66, 3'd4,
                 1, 0, 4'd5, 8'h55, 3'd3, 4'd0);
    tbl[12] = mk(0, 4'h0, 4'd0, 0, 3'd0, 8'h00, 3'd4, 0, 0, 0, 0, 0, 4'd0);

    do_reset();

    for (int i = 0; i < 13; i++) begin
      alloc_valid  = tbl[i].av;
      alloc_opcode = tbl[i].op;
      alloc_dest   = tbl[i].dst;
      wb_valid     = tbl[i].wv;
      wb_tag       = tbl[i].wt;
      wb_value     = tbl[i].wval;
      #1;
      if (tbl[i].av)
        chk($sformatf("v%0d alloc_tag", i), int'(alloc_tag),
            int'(tbl[i].e_atag));
      tick();
      chk($sformatf("v%0d ret_valid", i), int'(ret_valid),
          int'(tbl[i].e_rv));
      chk($sformatf("v%0d count", i), int'(count), int'(tbl[i].e_cnt));
      if (tbl[i].e_rv) begin
        chk($sformatf("v%0d ret_tag", i), int'(ret_tag),
            int'(tbl[i].e_rtag));
        chk($sformatf("v%0d ret_dest", i), int'(ret_dest),
            int'(tbl[i].e_dst));
        chk($sformatf("v%0d ret_value", i), int'(ret_value),
            int'(tbl[i].e_val));
        chk($sformatf("v%0d ret_wen", i), int'(ret_wen),
            int'(tbl[i].e_wen));
      end
    end
    idle_in();

    // full buffer
    do_reset();
    for (int i = 0; i < 8; i++) begin
      alloc_valid  = 1'b1;
      alloc_opcode = 4'h1;
      alloc_dest   = 4'(i);
      #1;
      chk("full alloc_tag", int'(alloc_tag), i);
      tick();
    end
    chk("full flag", int'(full), 1);
    chk("full count", int'(count), 8);
    chk("full ready", int'(alloc_ready), 0);
    chk("full empty", int'(empty), 0);
    alloc_dest = 4'd9;
    tick();
    chk("ninth count", int'(count), 8);
    chk("ninth tail", int'(alloc_tag), 0);
    idle_in();
    wb_valid = 1'b1;
    wb_tag   = 3'd0;
    wb_value = 8'hA0;
    tick();
    idle_in();
    chk("full wb ret_valid", int'(ret_valid), 0);
    chk("full wb ready", int'(alloc_ready), 0);
    tick();
    chk("full ret_valid", int'(ret_valid), 1);
    chk("full ret_tag", int'(ret_tag), 0);
    chk("full ret_value", int'(ret_value), 'hA0);
    chk("full after count", int'(count), 7);
    chk("full after ready", int'(alloc_ready), 1);

    // wrap: alloc k, wb k-1, retire k-2 each cycle
    do_reset();
    for (int k = 0; k < 14; k++) begin
      idle_in();
      if (k < 12) begin
        alloc_valid  = 1'b1;
        alloc_opcode = 4'h1;
        alloc_dest   = 4'(k);
      end
      if (k >= 1 && k <= 12) begin
        wb_valid = 1'b1;
        wb_tag   = 3'((k - 1) % 8);
        wb_value = 8'(8'h40 + k - 1);
      end
      #1;
      if (k < 12)
        chk("wrap alloc_tag", int'(alloc_tag), k % 8);
      tick();
      if (k >= 2) begin
        chk("wrap ret_valid", int'(ret_valid), 1);
        chk("wrap ret_tag", int'(ret_tag), (k - 2) % 8);
        chk("wrap ret_value", int'(ret_value), 'h40 + k - 2);
        chk("wrap ret_dest", int'(ret_dest), k - 2);
      end else begin
        chk("wrap ret_valid", int'(ret_valid), 0);
      end
      if (k <= 11)
        chk("wrap count", int'(count), (k == 0) ? 1 : 2);
      else
        chk("wrap count", int'(count), 13 - k);
    end
    idle_in();

    // mid-operation reset
    do_reset();
    for (int i = 0; i < 5; i++) begin
      alloc_valid = 1'b1;
      alloc_dest  = 4'(i);
      tick();
    end
    idle_in();
    for (int i = 1; i < 3; i++) begin
      wb_valid = 1'b1;
      wb_tag   = 3'(i);
      wb_value = 8'(i);
      tick();
    end
    idle_in();
    chk("mid count", int'(count), 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid rst count", int'(count), 0);
    chk("mid rst empty", int'(empty), 1);
    chk("mid rst full", int'(full), 0);
    chk("mid rst ready", int'(alloc_ready), 1);
    chk("mid rst ret_valid", int'(ret_valid), 0);
    chk("mid rst alloc_tag", int'(alloc_tag), 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid no ret", int'(ret_valid), 0);
    end
    alloc_valid = 1'b1;
    #1;
    chk("mid next tag", int'(alloc_tag), 0);
    tick();
    idle_in();
    chk("mid next count", int'(count), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
